// File: rtl/rc4_prga_stream_if.sv
// Bus bundle for the RC4 keystream/decrypt engine: start/finish control,
// shared S RAM port, ciphertext ROM port and plaintext D RAM port.
interface rc4_prga_stream_if #(
   parameter int MSG_AW = 8
);
   // Control: start is a one-cycle request pulse, honoured only while the
   // engine is idle. finish is a one-cycle completion pulse, and msg_ok /
   // fail_idx are stable from finish until the next accepted start.
   logic              start;
   logic              busy;
   logic              finish;
   logic              msg_ok;
   logic [MSG_AW-1:0] fail_idx;

   // S RAM (shared with the key-schedule engine)
   logic [7:0]        address_s;
   logic [7:0]        data_s;
   logic              wren_s;
   logic [7:0]        q_s;

   // Ciphertext ROM
   logic [MSG_AW-1:0] address_m;
   logic [7:0]        q_m;

   // Plaintext D RAM
   logic [MSG_AW-1:0] address_d;
   logic [7:0]        data_d;
   logic              wren_d;

   // Engine side
   modport master (
      input  start, q_s, q_m,
      output busy, finish, msg_ok, fail_idx,
             address_s, data_s, wren_s,
             address_m, address_d, data_d, wren_d
   );

   // Environment side (controller and memories)
   modport slave (
      output start, q_s, q_m,
      input  busy, finish, msg_ok, fail_idx,
             address_s, data_s, wren_s,
             address_m, address_d, data_d, wren_d
   );
endinterface

// File: rtl/rc4_prga_stream.sv
// RC4 PRGA engine: walks an already key-scheduled S box, produces one
// keystream byte per message byte, XORs it with the ROM ciphertext and
// writes the plaintext to D RAM. Optional screening against lowercase
// ASCII plus space aborts the message at the first illegal byte.
module rc4_prga_stream #(
   parameter int MSG_LEN  = 32,
   parameter int MSG_AW   = 8,
   parameter int RD_LAT   = 1,
   parameter int CHECK_EN = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   rc4_prga_stream_if.master       bus,
   output logic [3:0]              dbg_state
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LOAD   = 4'd1,
      RD_I   = 4'd2,
      WAIT_I = 4'd3,
      CAP_I  = 4'd4,
      RD_J   = 4'd5,
      WAIT_J = 4'd6,
      CAP_J  = 4'd7,
      WR_J   = 4'd8,
      WR_I   = 4'd9,
      RD_F   = 4'd10,
      WAIT_F = 4'd11,
      CAP_F  = 4'd12,
      WR_D   = 4'd13,
      NEXT   = 4'd14,
      DONE   = 4'd15
   } state_t;

   localparam logic [MSG_AW-1:0] LAST_K   = MSG_AW'(MSG_LEN - 1);
   localparam logic [1:0]        WAIT_END = 2'(RD_LAT - 1);

   state_t            state;
   state_t            state_nx;
   logic [7:0]        i;
   logic [7:0]        j;
   logic [7:0]        si;
   logic [7:0]        sj;
   logic [7:0]        sum;
   logic [MSG_AW-1:0] k;
   logic              abort;
   logic [1:0]        wait_cnt;
   logic              wait_done;
   logic [7:0]        pt;
   logic              pt_legal;
   logic              last_byte;

   assign wait_done = (wait_cnt == WAIT_END);
   assign pt        = bus.q_s ^ bus.q_m;
   assign pt_legal  = (pt == 8'h20) || ((pt >= 8'h61) && (pt <= 8'h7A));
   assign last_byte = abort || (k == LAST_K);
   assign dbg_state = state;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic: one fixed slot sequence per message byte.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.start) state_nx = LOAD;
         LOAD:    state_nx = RD_I;
         RD_I:    state_nx = WAIT_I;
         WAIT_I:  if (wait_done) state_nx = CAP_I;
         CAP_I:   state_nx = RD_J;
         RD_J:    state_nx = WAIT_J;
         WAIT_J:  if (wait_done) state_nx = CAP_J;
         CAP_J:   state_nx = WR_J;
         WR_J:    state_nx = WR_I;
         WR_I:    state_nx = RD_F;
         RD_F:    state_nx = WAIT_F;
         WAIT_F:  if (wait_done) state_nx = CAP_F;
         CAP_F:   state_nx = WR_D;
         WR_D:    state_nx = NEXT;
         NEXT:    state_nx = last_byte ? DONE : RD_I;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath and registered outputs; each slot's effect appears on the
   // bus in the cycle after that slot, so write enables are single pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i             <= '0;
         j             <= '0;
         k             <= '0;
         si            <= '0;
         sj            <= '0;
         sum           <= '0;
         abort         <= 1'b0;
         wait_cnt      <= '0;
         bus.busy      <= 1'b0;
         bus.finish    <= 1'b0;
         bus.msg_ok    <= 1'b0;
         bus.fail_idx  <= '0;
         bus.address_s <= '0;
         bus.data_s    <= '0;
         bus.wren_s    <= 1'b0;
         bus.address_m <= '0;
         bus.address_d <= '0;
         bus.data_d    <= '0;
         bus.wren_d    <= 1'b0;
      end else begin
         bus.wren_s <= 1'b0;
         bus.wren_d <= 1'b0;
         bus.busy   <= (state_nx != IDLE) && (state_nx != DONE);
         bus.finish <= (state_nx == DONE);
         wait_cnt   <= '0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  i            <= '0;
                  j            <= '0;
                  k            <= '0;
                  abort        <= 1'b0;
                  bus.msg_ok   <= 1'b1;
                  bus.fail_idx <= '0;
               end
            end
            RD_I: begin
               i             <= i + 8'd1;
               bus.address_s <= i + 8'd1;
            end
            WAIT_I, WAIT_J, WAIT_F: begin
               if (!wait_done) wait_cnt <= wait_cnt + 2'd1;
            end
            CAP_I: begin
               si <= bus.q_s;
               j  <= j + bus.q_s;
            end
            RD_J: bus.address_s <= j;
            CAP_J: sj <= bus.q_s;
            WR_J: begin
               bus.address_s <= j;
               bus.data_s    <= si;
               bus.wren_s    <= 1'b1;
            end
            // When i==j, sj equals si, so both writes store si and S is unchanged.
            WR_I: begin
               bus.address_s <= i;
               bus.data_s    <= sj;
               bus.wren_s    <= 1'b1;
               sum           <= si + sj;
            end
            RD_F: begin
               bus.address_s <= sum;
               bus.address_m <= k;
            end
            CAP_F: begin
               bus.data_d    <= pt;
               bus.address_d <= k;
               if ((CHECK_EN != 0) && !pt_legal) begin
                  bus.msg_ok   <= 1'b0;
                  bus.fail_idx <= k;
                  abort        <= 1'b1;
               end
            end
            WR_D: bus.wren_d <= 1'b1;
            NEXT: begin
               if (!last_byte) k <= k + MSG_AW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_prga_stream.sv
// Directed bench for rc4_prga_stream. Three engines with different
// length/latency/screening settings, each with its own S RAM, ROM and
// D RAM model.
module tb_rc4_prga_stream;

   localparam int NI = 3;

   logic        clk;
   logic        reset;
   logic        start_v   [NI];
   logic        load_v    [NI];
   logic        busy_v    [NI];
   logic        finish_v  [NI];
   logic        msg_ok_v  [NI];
   logic [7:0]  fail_v    [NI];
   logic [3:0]  state_v   [NI];
   logic [56:0] outs_v    [NI];
   logic [7:0]  rom_img   [NI][256];

   int n_pass;
   int n_checks;

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine instances and their memory models
   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LEN = (g == 2) ? 256 : 2;
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
      localparam int CHK = (g == 0) ? 1 : 0;

      rc4_prga_stream_if #(.MSG_AW(8)) bus ();
      logic [3:0] dbg;
      logic [7:0] s_mem  [256];
      logic [7:0] d_mem  [256];
      logic [7:0] s_pipe [3];
      logic [7:0] m_pipe [3];
      logic [8:0] wcnt;
      logic       order_err;

      rc4_prga_stream #(
         .MSG_LEN(LEN), .MSG_AW(8), .RD_LAT(LAT), .CHECK_EN(CHK)
      ) dut (
         .clk(clk),
         .reset(reset),
         .bus(bus.master),
         .dbg_state(dbg)
      );

      assign bus.start   = start_v[g];
      assign bus.q_s     = s_pipe[LAT-1];
      assign bus.q_m     = m_pipe[LAT-1];
      assign busy_v[g]   = bus.busy;
      assign finish_v[g] = bus.finish;
      assign msg_ok_v[g] = bus.msg_ok;
      assign fail_v[g]   = bus.fail_idx;
      assign state_v[g]  = dbg;
      assign outs_v[g]   = {bus.busy, bus.finish, bus.msg_ok, bus.fail_idx,
                            bus.address_s, bus.data_s, bus.wren_s,
                            bus.address_m, bus.address_d, bus.data_d,
                            bus.wren_d, dbg};

      // Memories: load gives identity S and cleared D; reads are RD_LAT deep.
      always_ff @(posedge clk) begin
         if (load_v[g]) begin
            for (int a = 0; a < 256; a++) begin
               s_mem[a] <= 8'(a);
               d_mem[a] <= 8'h00;
            end
            wcnt      <= '0;
            order_err <= 1'b0;
         end else begin
            if (bus.wren_s) s_mem[bus.address_s] <= bus.data_s;
            if (bus.wren_d) begin
               d_mem[bus.address_d] <= bus.data_d;
               if ({1'b0, bus.address_d} != wcnt) order_err <= 1'b1;
               wcnt <= wcnt + 9'd1;
            end
         end
         s_pipe[0] <= s_mem[bus.address_s];
         s_pipe[1] <= s_pipe[0];
         s_pipe[2] <= s_pipe[1];
         m_pipe[0] <= rom_img[g][bus.address_m];
         m_pipe[1] <= m_pipe[0];
         m_pipe[2] <= m_pipe[1];
      end
   end

   // Scoreboard compare
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Driver: one-cycle load of identity S / cleared D for engine n
   task automatic load(input int n);
      load_v[n] = 1'b1;
      @(posedge clk); #1;
      load_v[n] = 1'b0;
   endtask

   // Driver: start engine n; the edge that samples start is edge 0 and cyc
   // returns the edge number after which finish was seen (or limit).
   // A stray start pulse is issued at edge stray_at when nonzero.
   task automatic run(input int n, input int limit, input int stray_at, output int cyc);
      start_v[n] = 1'b1;
      @(posedge clk); #1;
      start_v[n] = 1'b0;
      chk("busy_after_start", 64'(busy_v[n]), 64'd1);
      cyc = 0;
      while (cyc < limit) begin
         @(posedge clk); #1;
         cyc++;
         start_v[n] = (cyc == stray_at);
         if (finish_v[n]) break;
      end
      start_v[n] = 1'b0;
   endtask

   int         cyc;
   logic       seen;
   logic [7:0] ms [256];
   logic [7:0] mi, mj, mt, mexp;

   initial begin
      n_pass   = 0;
      n_checks = 0;
      reset    = 1'b0;
      for (int n = 0; n < NI; n++) begin
         start_v[n] = 1'b0;
         load_v[n]  = 1'b0;
         for (int a = 0; a < 256; a++) rom_img[n][a] = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int n = 0; n < NI; n++) chk($sformatf("reset_outs_%0d", n), 64'(outs_v[n]), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Identity S, RD_LAT=1, {63,67} -> {61,62}
      rom_img[0][0] = 8'h63;
      rom_img[0][1] = 8'h67;
      load(0);
      run(0, 100, 0, cyc);
      chk("t1_finish_cycle", 64'(cyc), 64'd27);
      chk("t1_busy_in_done", 64'(busy_v[0]), 64'd0);
      chk("t1_msg_ok", 64'(msg_ok_v[0]), 64'd1);
      chk("t1_fail_idx", 64'(fail_v[0]), 64'd0);
      chk("t1_d0", 64'(g_dut[0].d_mem[0]), 64'h61);
      chk("t1_d1", 64'(g_dut[0].d_mem[1]), 64'h62);
      chk("t1_s2", 64'(g_dut[0].s_mem[2]), 64'h03);
      chk("t1_s3", 64'(g_dut[0].s_mem[3]), 64'h02);
      chk("t1_s5", 64'(g_dut[0].s_mem[5]), 64'h05);
      chk("t1_wcnt", 64'(g_dut[0].wcnt), 64'd2);
      chk("t1_order", 64'(g_dut[0].order_err), 64'd0);
      @(posedge clk); #1;
      chk("t1_finish_one_cycle", 64'(finish_v[0]), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("t1_msg_ok_held", 64'(msg_ok_v[0]), 64'd1);

      // Same stimulus with RD_LAT=3, no screening
      rom_img[1][0] = 8'h63;
      rom_img[1][1] = 8'h67;
      load(1);
      run(1, 200, 0, cyc);
      chk("t2_finish_cycle", 64'(cyc), 64'd39);
      chk("t2_msg_ok", 64'(msg_ok_v[1]), 64'd1);
      chk("t2_d0", 64'(g_dut[1].d_mem[0]), 64'h61);
      chk("t2_d1", 64'(g_dut[1].d_mem[1]), 64'h62);
      chk("t2_s2", 64'(g_dut[1].s_mem[2]), 64'h03);
      chk("t2_s3", 64'(g_dut[1].s_mem[3]), 64'h02);
      chk("t2_wcnt", 64'(g_dut[1].wcnt), 64'd2);

      // Screening abort on byte 0: plaintext 02 is illegal
      rom_img[0][0] = 8'h00;
      rom_img[0][1] = 8'h67;
      load(0);
      run(0, 100, 0, cyc);
      chk("t3_finish_cycle", 64'(cyc), 64'd14);
      chk("t3_msg_ok", 64'(msg_ok_v[0]), 64'd0);
      chk("t3_fail_idx", 64'(fail_v[0]), 64'd0);
      chk("t3_d0", 64'(g_dut[0].d_mem[0]), 64'h02);
      chk("t3_wcnt", 64'(g_dut[0].wcnt), 64'd1);

      // Screening abort on the last byte: plaintext 05 is illegal
      rom_img[0][0] = 8'h63;
      rom_img[0][1] = 8'h00;
      load(0);
      run(0, 100, 0, cyc);
      chk("t3b_finish_cycle", 64'(cyc), 64'd27);
      chk("t3b_msg_ok", 64'(msg_ok_v[0]), 64'd0);
      chk("t3b_fail_idx", 64'(fail_v[0]), 64'd1);
      chk("t3b_d1", 64'(g_dut[0].d_mem[1]), 64'h05);
      chk("t3b_wcnt", 64'(g_dut[0].wcnt), 64'd2);

      // No screening: illegal bytes are all written, msg_ok stays 1
      rom_img[1][0] = 8'h00;
      rom_img[1][1] = 8'h00;
      load(1);
      run(1, 200, 0, cyc);
      chk("t4_finish_cycle", 64'(cyc), 64'd39);
      chk("t4_msg_ok", 64'(msg_ok_v[1]), 64'd1);
      chk("t4_fail_idx", 64'(fail_v[1]), 64'd0);
      chk("t4_d0", 64'(g_dut[1].d_mem[0]), 64'h02);
      chk("t4_d1", 64'(g_dut[1].d_mem[1]), 64'h05);
      chk("t4_wcnt", 64'(g_dut[1].wcnt), 64'd2);

      // Full 256-byte message, RD_LAT=2: i wraps, k ends at 255
      for (int a = 0; a < 256; a++) rom_img[2][a] = 8'(a * 37 + 11);
      load(2);
      run(2, 5000, 0, cyc);
      chk("t5_finish_cycle", 64'(cyc), 64'd4097);
      chk("t5_msg_ok", 64'(msg_ok_v[2]), 64'd1);
      chk("t5_wcnt", 64'(g_dut[2].wcnt), 64'd256);
      chk("t5_order", 64'(g_dut[2].order_err), 64'd0);
      for (int a = 0; a < 256; a++) ms[a] = 8'(a);
      mi = 8'd0;
      mj = 8'd0;
      for (int kk = 0; kk < 256; kk++) begin
         mi     = mi + 8'd1;
         mj     = mj + ms[mi];
         mt     = ms[mi];
         ms[mi] = ms[mj];
         ms[mj] = mt;
         mexp   = ms[8'(ms[mi] + ms[mj])] ^ rom_img[2][kk];
         chk($sformatf("t5_d%0d", kk), 64'(g_dut[2].d_mem[kk]), 64'(mexp));
      end

      // Reset pulsed during WR_J of the first byte
      rom_img[0][0] = 8'h63;
      rom_img[0][1] = 8'h67;
      load(0);
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(posedge clk); #1;
         if (state_v[0] == 4'd8) seen = 1'b1;
      end
      chk("t6_reached_wr_j", 64'(seen), 64'd1);
      reset = 1'b0;
      #1;
      chk("t6_outs_zero", 64'(outs_v[0]), 64'd0);
      @(posedge clk); #2;
      chk("t6_held_idle", 64'(outs_v[0]), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Re-initialise and rerun, with a stray start while busy
      load(0);
      run(0, 100, 5, cyc);
      chk("t6_finish_cycle", 64'(cyc), 64'd27);
      chk("t6_msg_ok", 64'(msg_ok_v[0]), 64'd1);
      chk("t6_d0", 64'(g_dut[0].d_mem[0]), 64'h61);
      chk("t6_d1", 64'(g_dut[0].d_mem[1]), 64'h62);
      chk("t6_wcnt", 64'(g_dut[0].wcnt), 64'd2);
      repeat (4) @(posedge clk);
      #1;
      chk("t6_stray_start_ignored", 64'(busy_v[0]), 64'd0);
      chk("t6_state_idle", 64'(state_v[0]), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
